imem_loader: RTL and testbench

Boot-time programmer for the instruction memory of the single-cycle RISC-V core: the writer side of the byte-addressed instruction store that the core's fetch path reads. Accepts a framed byte stream over a valid/ready handshake, writes the payload into instruction memory byte by byte and verifies a checksum. Holds the core in reset until a complete, valid image has been loaded.

---
 rtl/imem_loader.sv | 189 ++++++++++++++++++
 tb/tb_imem_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream -> byte writes, checksum verify, core reset gating.
// Optional zero fill of the unused memory tail is enabled by defining LOADER_ZERO_FILL_EN.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
`ifdef LOADER_ZERO_FILL_EN
        S_FILL   = 3'd5,
`endif
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t        state_r, state_s;
    logic [15:0]   len_r;
    logic [AW:0]   addr_r;
    logic [7:0]    sum_r;
    logic          in_ready_r, mem_we_r, core_rst_r, busy_r, done_r, err_r;
    logic [AW-1:0] mem_addr_r;
    logic [7:0]    mem_wdata_r;

    logic          accept_s, len_bad_s, last_byte_s, addr_full_s;
    logic [15:0]   len_s;
    logic [AW:0]   addr_next_s;
    logic          in_ready_s, busy_s, done_s, err_s, core_rst_s;

    assign accept_s    = in_valid & in_ready_r;
    assign len_s       = {len_r[15:8], in_data};
    assign len_bad_s   = (len_s == 16'd0) || ({1'b0, len_s} > DEPTH_L) || (len_s[1:0] != 2'b00);
    assign addr_next_s = addr_r + {{AW{1'b0}}, 1'b1};
    assign last_byte_s = (17'(addr_next_s) == {1'b0, len_r});
    // The counter is one bit wider than the address so DEPTH itself marks "past the end".
    assign addr_full_s = (17'(addr_r) == DEPTH_L);

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   if (start) state_s = S_LEN_HI; else state_s = S_IDLE;
            S_LEN_HI: if (accept_s) state_s = S_LEN_LO; else state_s = S_LEN_HI;
            S_LEN_LO: begin
                if (accept_s) state_s = len_bad_s ? S_ERR : S_DATA;
                else          state_s = S_LEN_LO;
            end
            S_DATA:   if (accept_s && last_byte_s) state_s = S_CSUM; else state_s = S_DATA;
            S_CSUM: begin
                if (accept_s) begin
                    if (in_data == sum_r) begin
`ifdef LOADER_ZERO_FILL_EN
                        state_s = addr_full_s ? S_DONE : S_FILL;
`else
                        state_s = S_DONE;
`endif
                    end else begin
                        state_s = S_ERR;
                    end
                end else begin
                    state_s = S_CSUM;
                end
            end
`ifdef LOADER_ZERO_FILL_EN
            S_FILL:   if (addr_full_s) state_s = S_DONE; else state_s = S_FILL;
`endif
            S_DONE:   if (start) state_s = S_LEN_HI; else state_s = S_DONE;
            S_ERR:    if (start) state_s = S_LEN_HI; else state_s = S_ERR;
            default:  state_s = S_IDLE;
        endcase
    end

    // Output levels decoded from the upcoming state so they can be registered
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        core_rst_s = 1'b1;
        case (state_s)
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
`ifdef LOADER_ZERO_FILL_EN
            S_FILL:  busy_s = 1'b1;
`endif
            S_DONE: begin
                done_s     = 1'b1;
                core_rst_s = 1'b0;
            end
            S_ERR:   err_s = 1'b1;
            default: in_ready_s = 1'b0;
        endcase
    end

    // State and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            core_rst_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            in_ready_r <= in_ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
            core_rst_r <= core_rst_s;
        end
    end

    // Length capture, address/checksum counters and the registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r       <= 16'd0;
            addr_r      <= '0;
            sum_r       <= 8'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 8'd0;
        end else begin
            mem_we_r <= 1'b0;
            case (state_r)
                S_LEN_HI: if (accept_s) len_r[15:8] <= in_data;
                S_LEN_LO: if (accept_s) len_r <= len_s;
                S_DATA: begin
                    if (accept_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= addr_r[AW-1:0];
                        mem_wdata_r <= in_data;
                        addr_r      <= addr_next_s;
                        sum_r       <= sum_r + in_data;
                    end
                end
`ifdef LOADER_ZERO_FILL_EN
                S_FILL: begin
                    if (!addr_full_s) begin
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= addr_r[AW-1:0];
                        mem_wdata_r <= 8'h00;
                        addr_r      <= addr_next_s;
                    end
                end
`endif
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        addr_r <= '0;
                        sum_r  <= 8'd0;
                    end
                end
                default: mem_we_r <= 1'b0;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign core_rst  = core_rst_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random images against a frame-level model.
module tb_imem_loader;
`ifdef LOADER_ZERO_FILL_EN
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam bit FILL  = 1'b1;
`else
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam bit FILL  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, start, in_valid;
    logic [7:0] in_data;
    logic in_ready, mem_we, core_rst, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [7:0] mem_wdata;

    int checks = 0;
    int errors = 0;
    int wa_q[$];
    int wd_q[$];
    logic [7:0] pay_q[$];

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(int'(mem_addr));
            wd_q.push_back(int'(mem_wdata));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        int g;
        int n;
        if (stall) begin
            in_valid = 1'b0;
            n = $urandom_range(0, 3);
            repeat (n) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        g = 0;
        while (in_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Full load of pay_q framed with the given length; expectations come from the frame rules.
    task automatic run_load(input int len, input bit stall, input bit corrupt);
        logic [15:0] l16;
        logic [7:0]  sum, cs;
        bit len_ok, ok;
        int ea[$];
        int ed[$];
        int n, explat;
        l16 = len[15:0];
        sum = 8'd0;
        foreach (pay_q[i]) sum = sum + pay_q[i];
        cs = corrupt ? sum + 8'd1 : sum;
        len_ok = (len != 0) && (len <= DEPTH) && (len % 4 == 0);
        ok = len_ok && !corrupt;
        if (len_ok) foreach (pay_q[i]) begin ea.push_back(i); ed.push_back(int'(pay_q[i])); end
        if (ok && FILL) for (int a = len; a < DEPTH; a++) begin ea.push_back(a); ed.push_back(0); end
        explat = (ok && FILL && len != DEPTH) ? DEPTH - len + 1 : 0;

        wa_q.delete();
        wd_q.delete();
        do_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("core_rst_after_start", {31'd0, core_rst}, 32'd1);
        send(l16[15:8], stall);
        send(l16[7:0], stall);
        if (len_ok) begin
            foreach (pay_q[i]) send(pay_q[i], stall);
            send(cs, stall);
        end
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < DEPTH + 8) begin
            @(negedge clk);
            n++;
        end
        chk("completion_latency", n, explat);
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("err", {31'd0, err}, {31'd0, !ok});
        chk("core_rst", {31'd0, core_rst}, {31'd0, !ok});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("in_ready_end", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("write_count", wa_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
            chk("write_addr", wa_q[i], ea[i]);
            chk("write_data", wd_q[i], ed[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic load_image();
        pay_q = '{8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h93};
    endtask

    task automatic random_payload(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        load_image();
        run_load(8, 1'b0, 1'b0);
        run_load(8, 1'b0, 1'b1);

        pay_q.delete();
        run_load(6, 1'b0, 1'b0);
        run_load(0, 1'b0, 1'b0);
        run_load(DEPTH + 4, 1'b0, 1'b0);

        load_image();
        run_load(8, 1'b1, 1'b0);

        // Reset in the middle of the payload, then a clean reload
        do_start();
        send(8'h00, 1'b0);
        send(8'h08, 1'b0);
        for (int i = 0; i < 3; i++) send(pay_q[i], 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midload_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_load(8, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            len = 4 * $urandom_range(1, ((DEPTH < 64) ? DEPTH : 64) / 4);
            random_payload(len);
            run_load(len, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        random_payload(DEPTH);
        run_load(DEPTH, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
